// File: rtl/bm_jk_cmd_seq_if.sv
// bm_jk_cmd_seq_if: command handshake and J-K drive/feedback bundle for the
// J-K command sequencer. The master side issues commands and returns flop q;
// the slave side (the sequencer) drives j/k and status.
interface bm_jk_cmd_seq_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic             q_fb;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, q_fb,
    input  cmd_ready, j, k, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, q_fb,
    output cmd_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/bm_jk_cmd_seq.sv
// bm_jk_cmd_seq: queues HOLD/RESET/SET/TOGGLE commands in a small FIFO and
// plays each one out on the registered j/k drive for its repeat length.
// Optional feature macro: JK_SEQ_CHECK_EN -- models the expected flop output
// and raises a sticky err when the q feedback disagrees.
module bm_jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  bm_jk_cmd_seq_if.slave     bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = CNT_W + 2;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;
  logic [CNT_W-1:0] head_cnt;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       jk;
  logic [1:0]       jk_n;
  logic             busy_reg;
  logic             done_reg;

  // Ready depends only on the registered occupancy, so a same-cycle pop
  // never opens a slot in a full FIFO.
  assign full          = (count == FULL_CNT);
  assign empty         = (count == {(AW + 1){1'b0}});
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;

  assign head     = mem[rd_ptr];
  assign head_op  = head[EW-1 -: 2];
  assign head_len = head[CNT_W-1:0];
  // A zero length is played as a single cycle.
  assign head_cnt = (head_len == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (head_len - CNT_W'(1));

  // Command storage: data only, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_op, bus.cmd_len};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer next state: pop and load a command whenever the current one ends.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    jk_n    = jk;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          jk_n    = head_op;
          cnt_n   = head_cnt;
          state_n = RUN;
        end else begin
          jk_n    = 2'b00;
          cnt_n   = {CNT_W{1'b0}};
        end
      end
      RUN: begin
        if (cnt != {CNT_W{1'b0}}) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (!empty) begin
          pop   = 1'b1;
          jk_n  = head_op;
          cnt_n = head_cnt;
        end else begin
          jk_n    = 2'b00;
          cnt_n   = {CNT_W{1'b0}};
          state_n = IDLE;
        end
      end
      default: begin
        jk_n    = 2'b00;
        cnt_n   = {CNT_W{1'b0}};
        state_n = IDLE;
      end
    endcase
  end

  // Sequencer state plus registered j/k, busy and done (done marks the last drive cycle).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      jk       <= 2'b00;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      jk       <= jk_n;
      busy_reg <= (state_n == RUN);
      done_reg <= (state_n == RUN) && (cnt_n == {CNT_W{1'b0}});
    end
  end

  assign bus.j    = jk[1];
  assign bus.k    = jk[0];
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

`ifdef JK_SEQ_CHECK_EN
  logic exp_q;
  logic exp_q_n;
  logic armed;
  logic err_reg;

  // Flop behaviour for the j/k driven this cycle.
  always_comb begin
    case (jk)
      2'b01:   exp_q_n = 1'b0;
      2'b10:   exp_q_n = 1'b1;
      2'b11:   exp_q_n = ~exp_q;
      default: exp_q_n = exp_q;
    endcase
  end

  // Expected-q tracking and sticky mismatch flag, armed from the first drive cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      exp_q   <= 1'b0;
      armed   <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      exp_q <= exp_q_n;
      armed <= armed | busy_reg;
      if ((armed || busy_reg) && (bus.q_fb != exp_q_n)) begin
        err_reg <= 1'b1;
      end else begin
        err_reg <= err_reg;
      end
    end
  end

  assign bus.err = err_reg;
`else
  logic unused_q_fb;
  assign unused_q_fb = bus.q_fb;
  assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_bm_jk_cmd_seq.sv
// tb_bm_jk_cmd_seq: directed checks of the J-K command sequencer with a
// behavioural J-K flop closing the q feedback loop.
module tb_bm_jk_cmd_seq;
  logic clk;
  logic clr;
  logic flop_q;
  logic force_q;
  logic err_e;
  int   vectors;
  int   miscompares;

  bm_jk_cmd_seq_if #(.CNT_W(4)) bus ();

  bm_jk_cmd_seq #(.DEPTH(4), .CNT_W(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream J-K flop samples j/k on the falling edge.
  always @(negedge clk or posedge clr) begin
    if (clr) flop_q <= 1'b0;
    else begin
      case ({bus.j, bus.k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end

  assign bus.q_fb = force_q ? 1'b1 : flop_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] len);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
  endtask

  // Compares {j,k,busy,done,cmd_ready,err} against the expected values.
  task automatic chk(input string tag, input logic [1:0] jk, input logic b,
                     input logic d, input logic r, input logic e);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.j, bus.k, bus.busy, bus.done, bus.cmd_ready, bus.err};
    exp = {jk, b, d, r, e};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed jk/busy/done/rdy/err=%b required %b", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    force_q     = 1'b0;
`ifdef JK_SEQ_CHECK_EN
    err_e = 1'b1;
`else
    err_e = 1'b0;
`endif
    clr = 1'b1;
    drive(1'b0, 2'd0, 4'd0);

    // Reset and idle
    repeat (3) step();
    chk("reset_hold", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    clr = 1'b0;
    repeat (4) step();
    chk("idle", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single SET len=3
    drive(1'b1, 2'd2, 4'd3);
    step();
    drive(1'b0, 2'd0, 4'd0);
    step(); chk("set_c1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("set_c2", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("set_c3", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("set_end", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: TOGGLE len0, RESET len2, HOLD len1
    drive(1'b1, 2'd3, 4'd0);
    step();
    drive(1'b1, 2'd1, 4'd2);
    step(); chk("b2b_tog", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 4'd1);
    step(); chk("b2b_rst1", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 4'd0);
    step(); chk("b2b_rst2", 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("b2b_hold", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("b2b_end", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full FIFO behind a SET len=15
    drive(1'b1, 2'd2, 4'd15);
    step();
    drive(1'b1, 2'd3, 4'd1);
    step(); chk("full_q1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 4'd1);
    step();
    drive(1'b1, 2'd2, 4'd2);
    step();
    drive(1'b1, 2'd0, 4'd1);
    step(); chk("full_ready_low", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 4'd1);
    repeat (11) step();
    chk("full_pop_cycle", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk("full_a_tog", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 2'd0, 4'd0);
    chk("full_b_rst", 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("full_c_set1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("full_c_set2", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("full_d_hold", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("full_e_tog", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("full_end", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during cycle 2 of SET len=5 with two entries queued
    drive(1'b1, 2'd2, 4'd5);
    step();
    drive(1'b1, 2'd3, 4'd1);
    step(); chk("abort_c1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 4'd1);
    step();
    drive(1'b0, 2'd0, 4'd0);
    #2 clr = 1'b1;
    #1 chk("abort_async", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    clr = 1'b0;
    repeat (3) step();
    chk("abort_flushed", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 4'd1);
    step();
    drive(1'b0, 2'd0, 4'd0);
    step(); chk("post_abort_rst", 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("post_abort_end", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Checker with a following flop: SET len1 then TOGGLE len2
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(1'b1, 2'd2, 4'd1);
    step();
    drive(1'b1, 2'd3, 4'd2);
    step(); chk("chk_set", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 4'd0);
    step(); chk("chk_tog1", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("chk_tog2", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("chk_idle", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk("chk_no_err", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Same sequence, q_fb forced high during the expected-0 cycle
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(1'b1, 2'd2, 4'd1);
    step();
    drive(1'b1, 2'd3, 4'd2);
    step();
    drive(1'b0, 2'd0, 4'd0);
    step();
    force_q = 1'b1;
    chk("force_pre", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    force_q = 1'b0;
    chk("force_err", 2'b11, 1'b1, 1'b1, 1'b1, err_e);
    step(); chk("force_sticky1", 2'b00, 1'b0, 1'b0, 1'b1, err_e);
    repeat (3) step();
    chk("force_sticky2", 2'b00, 1'b0, 1'b0, 1'b1, err_e);
    clr = 1'b1;
    #1 chk("force_clr", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    clr = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
